// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - issue/operand/forwarding bundle between ID stage and fwd_scoreboard
//  master: ID-side controller (drives issue_*, src_*, hold, flush; receives fwd_sel, stall, busy)
//  slave : fwd_scoreboard
//  fwd_sel operand k occupies [k*FW +: FW] = {stage[SW-1:0], kind[1:0]}
interface fwd_scoreboard_if #(
    parameter int AW    = 3,
    parameter int DEPTH = 3,
    parameter int NSRC  = 2
);
    localparam int SW = $clog2(DEPTH);
    localparam int FW = SW + 2;

    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic [1:0]           issue_class;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC*AW-1:0]   src_addr;
    logic                 hold;
    logic                 flush;
    logic [NSRC*FW-1:0]   fwd_sel;
    logic                 stall;
    logic                 busy;

    modport master (
        output issue_valid, issue_rd, issue_class, src_valid, src_addr, hold, flush,
        input  fwd_sel, stall, busy
    );

    modport slave (
        input  issue_valid, issue_rd, issue_class, src_valid, src_addr, hold, flush,
        output fwd_sel, stall, busy
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight writer scoreboard with youngest-producer forwarding select and load-use stall
//  Ports: clk, rst (sync active-high), bus (fwd_scoreboard_if.slave).
//  Optional FWD_PERF_CNT_EN: adds stall_cnt[31:0] / fwd_cnt[31:0] saturating event counters.
//  Entry 0 is EX, entry DEPTH-1 the oldest tracked stage; loads become forwardable at LOAD_LAT.
module fwd_scoreboard #(
    parameter int AW       = 3,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    fwd_scoreboard_if.slave   bus
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);
    localparam int SW = $clog2(DEPTH);
    localparam int FW = SW + 2;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_LOAD = 2'b10;

    logic          ent_v   [DEPTH];
    logic [AW-1:0] ent_rd  [DEPTH];
    logic [1:0]    ent_cls [DEPTH];

    logic [NSRC*FW-1:0] sel;
    logic [NSRC-1:0]    stall_op;
    logic               hit;
    int                 hit_i;
    logic [1:0]         hit_cls;

    // Scan oldest to youngest so the youngest matching producer overwrites older ones.
    always_comb begin
        sel      = '0;
        stall_op = '0;
        hit      = 1'b0;
        hit_i    = 0;
        hit_cls  = CLS_NONE;
        for (int k = 0; k < NSRC; k++) begin
            hit     = 1'b0;
            hit_i   = 0;
            hit_cls = CLS_NONE;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (bus.src_valid[k] && ent_v[i] && ent_rd[i] == bus.src_addr[k*AW +: AW]) begin
                    hit     = 1'b1;
                    hit_i   = i;
                    hit_cls = ent_cls[i];
                end
            end
            // A load that has not reached LOAD_LAT blocks the operand even if an older
            // producer of the same register exists further down the pipe.
            stall_op[k] = hit && hit_cls == CLS_LOAD && hit_i < LOAD_LAT && bus.issue_valid;
            if (hit && !stall_op[k]) begin
                sel[k*FW +: FW] = {SW'(hit_i), hit_cls};
            end
        end
    end

    assign bus.fwd_sel = sel;
    assign bus.stall   = |stall_op;

    always_comb begin
        bus.busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.busy = bus.busy | ent_v[i];
        end
    end

    logic issue_take;
    assign issue_take = bus.issue_valid && !bus.stall && !bus.flush && bus.issue_class != CLS_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_v[i]   <= 1'b0;
                ent_rd[i]  <= '0;
                ent_cls[i] <= CLS_NONE;
            end
        end else if (!bus.hold) begin
            for (int i = DEPTH - 1; i >= 2; i--) begin
                ent_v[i]   <= ent_v[i-1];
                ent_rd[i]  <= ent_rd[i-1];
                ent_cls[i] <= ent_cls[i-1];
            end
            // On flush the instruction currently in EX is killed as it moves to MEM.
            ent_v[1]   <= bus.flush ? 1'b0 : ent_v[0];
            ent_rd[1]  <= ent_rd[0];
            ent_cls[1] <= ent_cls[0];
            ent_v[0]   <= issue_take;
            ent_rd[0]  <= issue_take ? bus.issue_rd : '0;
            ent_cls[0] <= issue_take ? bus.issue_class : CLS_NONE;
        end
    end

`ifdef FWD_PERF_CNT_EN
    int          fwd_num;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_num = 0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel[k*FW +: 2] != CLS_NONE) begin
                fwd_num = fwd_num + 1;
            end
        end
        fwd_sum = {1'b0, fwd_cnt} + 33'(fwd_num);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!bus.hold) begin
            if (bus.stall) begin
                if (stall_cnt != 32'hFFFF_FFFF) begin
                    stall_cnt <= stall_cnt + 32'd1;
                end
            end else begin
                fwd_cnt <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
            end
        end
    end
`endif
endmodule
